i_type_exec_pipe: RTL and testbench
===================================

# i_type_exec_pipe

Two-stage pipelined execution unit for the full MIPS I-type ALU group (addi, addiu, slti, sltiu, andi, ori, xori, lui). It decodes the opcode internally, so it needs no external ALU_OP. It owns a 32-entry register file and accepts one instruction per cycle over a valid/ready handshake. It supersedes the single-cycle I-type datapath, adding width parametrisation, opcode decode, overflow trapping, hazard handling and a debug read port.

## Interface
- N, 32, datapath and register width; legal values 32 and 64.
- NREG, 32, register count; fixed by the 5-bit rs/rt fields, overriding it is illegal.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction is present.
- instr_ready  out  1  unit can accept an instruction this cycle.
- instruction  in  32  MIPS I-type word: opcode [31:26], rs [25:21], rt [20:16], imm [15:0].
- wb_valid  out  1  the WB register holds a completed instruction.
- wb_reg  out  5  destination rt of the WB register.
- wb_data  out  N  result in the WB register.
- wb_ovf  out  1  the WB entry trapped on signed overflow.
- wb_ill  out  1  the WB entry had an illegal opcode.
- dbg_addr  in  5  debug read address.
- dbg_data  out  N  combinational register-file read; R0 always reads 0.

## Operation
- Accept when instr_valid && instr_ready at a rising edge.
- At the accept edge, the EX register captures: opcode, rt, the rs operand and the extended immediate.
- Immediate extension:
  - andi/ori/xori zero-extend imm to N bits.
  - All other opcodes sign-extend imm to N bits.
- Results, all modulo 2^N:
  - addi/addiu: rs+imm.
  - slti: signed compare, result is 1 or 0.
  - sltiu: unsigned compare of rs against the sign-extended imm.
  - andi/ori/xori: bitwise on rs and the zero-extended imm.
  - lui: imm<<16; for N=64 the result is sign-extended from bit 31.
- addi traps on signed overflow: wb_ovf=1 and no register write. addiu never traps.
- Opcodes outside 001000..001111 are still accepted: wb_ill=1, wb_data=0, no register write.
- The EX→WB edge loads wb_valid, wb_reg, wb_data, wb_ovf and wb_ill. wb_valid=0 if EX was empty.
- The register file is written at the edge following WB load, only when wb_valid && !wb_ovf && !wb_ill && wb_reg!=0.
- R0 is never written and always reads 0.
- No downstream backpressure: the WB register is overwritten every cycle.
- Hazard (RAW): an incoming rs!=0 that matches the rt of a valid, writing EX or WB entry.
  - With FORWARD_EN: resolved by bypass.
  - Without FORWARD_EN: resolved by stalling (see Configuration).
- No other stall sources exist. instr_ready=1 whenever no hazard stall is active and rst is high.

## Timing
- Reset (asynchronous on rst low) clears:
  - all 32 registers to 0;
  - the EX and WB valid bits, wb_reg, wb_data, wb_ovf and wb_ill to 0;
  - instr_ready to 0.
- instr_ready rises combinationally once rst is high.
- Latency from accept edge k:
  - wb_* valid after edge k+1.
  - Register file updated at edge k+2.
  - dbg_data shows the new value after k+2.
- Throughput is 1 instruction per cycle with no hazards.
- Reset asserted mid-operation discards EX and WB contents; any in-flight write is lost.
- A dbg_addr read at the same cycle as a write returns the old value. Write-through is not provided.

## Configuration
- FORWARD_EN defined: the operand mux forwards at the accept edge with this priority:
  1. The EX-stage combinational ALU result, if EX rt matches rs.
  2. Else wb_data, if WB rt matches rs.
  3. Else the register file.
- Trapping or illegal entries are never forwarded. A matching trapping/illegal entry is skipped and the mux falls through to the next source.
- FORWARD_EN defined: instr_ready is never deasserted for hazards.
- FORWARD_EN undefined:
  - instr_ready=0 while a hazard exists against EX or WB.
  - A dependent instruction behind its producer is accepted 3 cycles after the producer.
  - Results are identical to the FORWARD_EN build; only timing differs.

## Test plan
- Reset, then addi R16,R0,20; addi R17,R16,63 back-to-back → R16=20, R17=83. With FORWARD_EN: no stall. Without: instr_ready low for 2 cycles.
- addi R18,R0,-1; andi R19,R18,0xFFFF; sltiu R20,R18,-1; slti R21,R18,0 → R18=0xFFFFFFFF, R19=0x0000FFFF, R20=0, R21=1.
- lui R8,0x7FFF; ori R8,R8,0xFFFF; addi R9,R8,1 → R8=0x7FFFFFFF, wb_ovf=1 on the third instruction, R9 remains 0. addiu of the same values gives 0x80000000.
- addi R0,R0,5, then opcode 6'b000010 → R0 reads 0; the second instruction shows wb_ill=1 and no register changes.
- Stream 6 independent addi with rst pulsed low during the 4th → all registers 0 after reset. The 5th and 6th instructions, issued after release, land correctly at k+2.
- N=64 build: addi R1,R0,-10; lui R2,0x8000 → R1=0xFFFFFFFFFFFFFFF6, R2=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/i_type_exec_pipe.sv
// i_type_exec_pipe: two-stage (EX, WB) execution unit for the MIPS I-type ALU
// group (addi, addiu, slti, sltiu, andi, ori, xori, lui), with an internal
// 32-entry register file and a combinational debug read port.
// Optional feature macro: FORWARD_EN. When defined, RAW hazards are resolved
// by bypassing EX/WB results into the operand mux. When undefined, they are
// resolved by holding instr_ready low until the producer has reached the
// register file.
//
// Handshake: an instruction transfers on a rising clk edge where
// instr_valid && instr_ready. instr_ready never depends on instr_valid. It is
// low while rst is low and, in the stalling build, while the presented rs
// depends on a writing EX or WB entry. There is no downstream backpressure:
// the WB register is reloaded on every edge.
module i_type_exec_pipe #(
    parameter int N    = 32,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [31:0]  instruction,
    output logic         wb_valid,
    output logic [4:0]   wb_reg,
    output logic [N-1:0] wb_data,
    output logic         wb_ovf,
    output logic         wb_ill,
    input  logic [4:0]   dbg_addr,
    output logic [N-1:0] dbg_data
);

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // Register file; entry 0 is never written, so it stays at its reset value.
    logic [N-1:0] regs_q [NREG];

    // EX stage register.
    logic         ex_valid_q, ex_valid_d;
    logic [5:0]   ex_op_q,    ex_op_d;
    logic [4:0]   ex_rt_q,    ex_rt_d;
    logic [N-1:0] ex_rs_val_q, ex_rs_val_d;
    logic [N-1:0] ex_imm_q,   ex_imm_d;

    // WB stage register.
    logic         wb_valid_q, wb_valid_d;
    logic [4:0]   wb_reg_q,   wb_reg_d;
    logic [N-1:0] wb_data_q,  wb_data_d;
    logic         wb_ovf_q,   wb_ovf_d;
    logic         wb_ill_q,   wb_ill_d;

    // Incoming instruction fields.
    logic [5:0]   in_op;
    logic [4:0]   in_rs;
    logic [4:0]   in_rt;
    logic [15:0]  in_imm;
    logic         in_zext;
    logic [N-1:0] in_imm_ext;
    logic [N-1:0] rf_rs_val;
    logic [N-1:0] rs_operand;
    logic         accept;

    // EX-stage ALU outputs and hazard terms.
    logic [N-1:0] ex_sum;
    logic [N-1:0] ex_result;
    logic         ex_ovf;
    logic         ex_ill;
    logic         ex_writes;
    logic         wb_writes;
    logic         haz_ex;
    logic         haz_wb;
    logic         stall;

    assign in_op   = instruction[31:26];
    assign in_rs   = instruction[25:21];
    assign in_rt   = instruction[20:16];
    assign in_imm  = instruction[15:0];

    // Only the logical ops zero-extend; everything else (including illegal
    // opcodes, whose immediate is never used) sign-extends.
    assign in_zext    = (in_op == OP_ANDI) || (in_op == OP_ORI) || (in_op == OP_XORI);
    assign in_imm_ext = in_zext ? {{(N-16){1'b0}}, in_imm} : {{(N-16){in_imm[15]}}, in_imm};

    assign rf_rs_val  = (in_rs == 5'd0) ? '0 : regs_q[in_rs];
    assign accept     = instr_valid && instr_ready;

    assign ex_sum = ex_rs_val_q + ex_imm_q;

    // EX-stage ALU: opcode decode, result, overflow and illegal flags.
    always_comb begin
        ex_result = '0;
        ex_ovf    = 1'b0;
        ex_ill    = 1'b0;
        case (ex_op_q)
            OP_ADDI: begin
                ex_result = ex_sum;
                ex_ovf    = (ex_rs_val_q[N-1] == ex_imm_q[N-1]) && (ex_sum[N-1] != ex_rs_val_q[N-1]);
            end
            OP_ADDIU: ex_result = ex_sum;
            OP_SLTI:  ex_result = {{(N-1){1'b0}}, ($signed(ex_rs_val_q) < $signed(ex_imm_q))};
            OP_SLTIU: ex_result = {{(N-1){1'b0}}, (ex_rs_val_q < ex_imm_q)};
            OP_ANDI:  ex_result = ex_rs_val_q & ex_imm_q;
            OP_ORI:   ex_result = ex_rs_val_q | ex_imm_q;
            OP_XORI:  ex_result = ex_rs_val_q ^ ex_imm_q;
            // The immediate is already sign-extended, so the shift also
            // sign-extends from bit 31 when N is 64.
            OP_LUI:   ex_result = ex_imm_q << 16;
            default:  ex_ill    = 1'b1;
        endcase
    end

    // An entry counts as a producer only if it will really update the file.
    assign ex_writes = ex_valid_q && !ex_ovf && !ex_ill && (ex_rt_q != 5'd0);
    assign wb_writes = wb_valid_q && !wb_ovf_q && !wb_ill_q && (wb_reg_q != 5'd0);
    assign haz_ex    = ex_writes && (in_rs != 5'd0) && (in_rs == ex_rt_q);
    assign haz_wb    = wb_writes && (in_rs != 5'd0) && (in_rs == wb_reg_q);

`ifdef FORWARD_EN
    // Operand mux: youngest writing producer wins, register file last.
    always_comb begin
        rs_operand = rf_rs_val;
        stall      = 1'b0;
        if (haz_ex) begin
            rs_operand = ex_result;
        end else if (haz_wb) begin
            rs_operand = wb_data_q;
        end
    end
`else
    // Operand comes straight from the file; dependents wait for the write.
    always_comb begin
        rs_operand = rf_rs_val;
        stall      = haz_ex || haz_wb;
    end
`endif

    assign instr_ready = rst && !stall;

    // EX next state: capture on accept, otherwise insert a bubble.
    always_comb begin
        ex_valid_d  = accept;
        ex_op_d     = ex_op_q;
        ex_rt_d     = ex_rt_q;
        ex_rs_val_d = ex_rs_val_q;
        ex_imm_d    = ex_imm_q;
        if (accept) begin
            ex_op_d     = in_op;
            ex_rt_d     = in_rt;
            ex_rs_val_d = rs_operand;
            ex_imm_d    = in_imm_ext;
        end
    end

    // WB next state: always reloaded from EX; flags only meaningful when valid.
    always_comb begin
        wb_valid_d = ex_valid_q;
        wb_reg_d   = ex_rt_q;
        wb_data_d  = ex_result;
        wb_ovf_d   = ex_valid_q && ex_ovf;
        wb_ill_d   = ex_valid_q && ex_ill;
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q  <= 1'b0;
            ex_op_q     <= '0;
            ex_rt_q     <= '0;
            ex_rs_val_q <= '0;
            ex_imm_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            wb_ovf_q    <= 1'b0;
            wb_ill_q    <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op_q     <= ex_op_d;
            ex_rt_q     <= ex_rt_d;
            ex_rs_val_q <= ex_rs_val_d;
            ex_imm_q    <= ex_imm_d;
            wb_valid_q  <= wb_valid_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            wb_ovf_q    <= wb_ovf_d;
            wb_ill_q    <= wb_ill_d;
        end
    end

    // Register file write from the WB register, one edge after WB load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_writes) begin
            regs_q[wb_reg_q] <= wb_data_q;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_reg   = wb_reg_q;
    assign wb_data  = wb_data_q;
    assign wb_ovf   = wb_ovf_q;
    assign wb_ill   = wb_ill_q;

    // No write-through: a read in the cycle of a write sees the old value.
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_i_type_exec_pipe.sv
// Testbench for i_type_exec_pipe (N=32). Directed instruction vectors with
// hand-computed results; expected WB entries are queued at issue and a
// separate monitor compares them whenever wb_valid is seen.
module tb_i_type_exec_pipe;

    localparam int N = 32;
    localparam int W = 39;   // {ill, ovf, reg[4:0], data[31:0]}

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BAD   = 6'b000010;

`ifdef FORWARD_EN
    localparam int DEP_STALLS = 0;
`else
    localparam int DEP_STALLS = 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [31:0]  instruction = '0;
    logic         wb_valid;
    logic [4:0]   wb_reg;
    logic [N-1:0] wb_data;
    logic         wb_ovf;
    logic         wb_ill;
    logic [4:0]   dbg_addr = '0;
    logic [N-1:0] dbg_data;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    i_type_exec_pipe #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .wb_ovf      (wb_ovf),
        .wb_ill      (wb_ill),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [W-1:0] pack(input logic ill, input logic ovf,
                                          input logic [4:0] r, input logic [N-1:0] d);
        return {ill, ovf, r, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_reg(input logic [4:0] addr, input logic [N-1:0] req, input string name);
        dbg_addr = addr;
        #1;
        check(name, 64'(dbg_data), 64'(req));
    endtask

    // ---------------- driver ----------------
    // Presents an instruction at a falling edge, waits (bounded) for ready,
    // queues its expected WB entry and returns right after the accept edge.
    task automatic issue(input logic [31:0] ins, input logic [W-1:0] exp, output int stalls);
        int guard;
        guard  = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = ins;
        #1;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        stalls = guard;
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: ready stayed 0 for %0d cycles, required 1", guard);
            instr_valid = 1'b0;
        end else begin
            exp_q.push_back(exp);
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst && wb_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: got reg=%0d data=0x%08h, required no WB entry",
                             wb_reg, wb_data);
                end else begin
                    e = exp_q.pop_front();
                    if (wb_ill !== e[38] || wb_ovf !== e[37] || wb_reg !== e[36:32] ||
                        (!e[37] && wb_data !== e[31:0])) begin
                        errors++;
                        $display("FAIL wb_entry: got ill=%0b ovf=%0b reg=%0d data=0x%08h, required ill=%0b ovf=%0b reg=%0d data=0x%08h",
                                 wb_ill, wb_ovf, wb_reg, wb_data, e[38], e[37], e[36:32], e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int st;

        // Reset state.
        #12;
        check("reset_ready", 64'(instr_ready), 64'd0);
        check("reset_wb_valid", 64'(wb_valid), 64'd0);
        check("reset_wb_fields", 64'({wb_reg, wb_ovf, wb_ill}), 64'd0);
        check("reset_wb_data", 64'(wb_data), 64'd0);
        check_reg(5'd16, 32'd0, "reset_r16");
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("release_ready", 64'(instr_ready), 64'd1);

        // Back-to-back RAW dependency.
        issue(enc(OP_ADDI, 5'd0, 5'd16, 16'd20), pack(1'b0, 1'b0, 5'd16, 32'd20), st);
        issue(enc(OP_ADDI, 5'd16, 5'd17, 16'd63), pack(1'b0, 1'b0, 5'd17, 32'd83), st);
        check("raw_stall_cycles", 64'(st), 64'(DEP_STALLS));
        idle(4);
        check_reg(5'd16, 32'd20, "r16");
        check_reg(5'd17, 32'd83, "r17");

        // Sign / zero extension and compares.
        issue(enc(OP_ADDI,  5'd0,  5'd18, 16'hFFFF), pack(1'b0, 1'b0, 5'd18, 32'hFFFF_FFFF), st);
        issue(enc(OP_ANDI,  5'd18, 5'd19, 16'hFFFF), pack(1'b0, 1'b0, 5'd19, 32'h0000_FFFF), st);
        issue(enc(OP_SLTIU, 5'd18, 5'd20, 16'hFFFF), pack(1'b0, 1'b0, 5'd20, 32'd0), st);
        issue(enc(OP_SLTI,  5'd18, 5'd21, 16'h0000), pack(1'b0, 1'b0, 5'd21, 32'd1), st);
        issue(enc(OP_XORI,  5'd18, 5'd11, 16'h00FF), pack(1'b0, 1'b0, 5'd11, 32'hFFFF_FF00), st);
        idle(4);
        check_reg(5'd18, 32'hFFFF_FFFF, "r18");
        check_reg(5'd19, 32'h0000_FFFF, "r19");
        check_reg(5'd20, 32'd0, "r20");
        check_reg(5'd21, 32'd1, "r21");
        check_reg(5'd11, 32'hFFFF_FF00, "r11");

        // lui / ori, signed overflow trap, addiu wrap.
        issue(enc(OP_LUI,   5'd0, 5'd8,  16'h7FFF), pack(1'b0, 1'b0, 5'd8,  32'h7FFF_0000), st);
        issue(enc(OP_ORI,   5'd8, 5'd8,  16'hFFFF), pack(1'b0, 1'b0, 5'd8,  32'h7FFF_FFFF), st);
        issue(enc(OP_ADDI,  5'd8, 5'd9,  16'd1),    pack(1'b0, 1'b1, 5'd9,  32'd0), st);
        issue(enc(OP_ADDIU, 5'd8, 5'd10, 16'd1),    pack(1'b0, 1'b0, 5'd10, 32'h8000_0000), st);
        // A trapping entry is not a producer: no stall, old R9 (0) is read.
        issue(enc(OP_ADDI,  5'd9, 5'd23, 16'd2),    pack(1'b0, 1'b0, 5'd23, 32'd2), st);
        check("ovf_no_stall", 64'(st), 64'd0);
        idle(4);
        check_reg(5'd8,  32'h7FFF_FFFF, "r8");
        check_reg(5'd9,  32'd0, "r9_after_ovf");
        check_reg(5'd10, 32'h8000_0000, "r10");
        check_reg(5'd23, 32'd2, "r23");

        // R0 write suppression and illegal opcode.
        issue(enc(OP_ADDI, 5'd0, 5'd0, 16'd5),       pack(1'b0, 1'b0, 5'd0,  32'd5), st);
        issue(enc(OP_BAD,  5'd0, 5'd16, 16'h1234),   pack(1'b1, 1'b0, 5'd16, 32'd0), st);
        issue(enc(OP_ADDI, 5'd16, 5'd22, 16'd1),     pack(1'b0, 1'b0, 5'd22, 32'd21), st);
        check("ill_no_stall", 64'(st), 64'd0);
        idle(4);
        check_reg(5'd0,  32'd0,  "r0");
        check_reg(5'd16, 32'd20, "r16_after_ill");
        check_reg(5'd22, 32'd21, "r22");

        // Reset pulsed while the 4th of a stream is in flight.
        issue(enc(OP_ADDI, 5'd0, 5'd1, 16'd1), pack(1'b0, 1'b0, 5'd1, 32'd1), st);
        issue(enc(OP_ADDI, 5'd0, 5'd2, 16'd2), pack(1'b0, 1'b0, 5'd2, 32'd2), st);
        issue(enc(OP_ADDI, 5'd0, 5'd3, 16'd3), pack(1'b0, 1'b0, 5'd3, 32'd3), st);
        issue(enc(OP_ADDI, 5'd0, 5'd4, 16'd4), pack(1'b0, 1'b0, 5'd4, 32'd4), st);
        @(negedge clk);
        instr_valid = 1'b0;
        #3;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_ready", 64'(instr_ready), 64'd0);
        check("midreset_wb_valid", 64'(wb_valid), 64'd0);
        repeat (2) @(negedge clk);
        #3;
        rst = 1'b1;
        for (int r = 0; r < 32; r++) begin
            check_reg(5'(r), 32'd0, "post_reset_reg");
        end
        issue(enc(OP_ADDI, 5'd0, 5'd5, 16'd5), pack(1'b0, 1'b0, 5'd5, 32'd5), st);
        issue(enc(OP_ADDI, 5'd0, 5'd6, 16'd6), pack(1'b0, 1'b0, 5'd6, 32'd6), st);
        // Accept edge k of the 6th has just passed.
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);                       // between k+1 and k+2
        check_reg(5'd6, 32'd0, "r6_before_k2");
        check_reg(5'd5, 32'd5, "r5_at_k1");
        @(negedge clk);                       // after k+2
        check_reg(5'd6, 32'd6, "r6_after_k2");
        idle(3);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
